// File: rtl/dmem_apb_slave.sv
// APB data-memory slave: word-organised array with byte strobes, programmable
// wait states and PSLVERR on misaligned or out-of-range accesses.
module dmem_apb_slave #(
    parameter int          DEPTH       = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [31:0] paddr,
    input  logic [31:0] pwdata,
    input  logic [3:0]  pstrb,
    output logic [31:0] prdata,
    output logic        pready,
    output logic        pslverr
);

    localparam int          IW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]  CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t         state, state_nxt;
    logic [3:0]     cnt, cnt_nxt;
    logic           capture, go_resp;

    logic           lat_write, lat_err;
    logic [IW-1:0]  lat_idx;
    logic [31:0]    lat_wdata;
    logic [3:0]     lat_strb;

    logic [31:0]    mem [DEPTH];

    logic [31:0]    off;
    logic           dec_err;
    logic [IW-1:0]  dec_idx;

    logic           x_write, x_err;
    logic [IW-1:0]  x_idx;
    logic [31:0]    x_wdata;
    logic [3:0]     x_strb;

    // BASE_ADDR is word aligned, so off[1:0] equals paddr[1:0]
    assign off     = paddr - BASE_ADDR;
    assign dec_err = (off[1:0] != 2'b00) || (32'(off[31:2]) >= 32'(DEPTH));
    assign dec_idx = off[IW+1:2];

    // With zero wait states RESP is entered on the setup edge itself, so the
    // live bus is used; otherwise the values latched at setup are used.
    always_comb begin
        if (state == IDLE) begin
            x_write = pwrite;
            x_err   = dec_err;
            x_idx   = dec_idx;
            x_wdata = pwdata;
            x_strb  = pstrb;
        end else begin
            x_write = lat_write;
            x_err   = lat_err;
            x_idx   = lat_idx;
            x_wdata = lat_wdata;
            x_strb  = lat_strb;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        capture   = 1'b0;
        go_resp   = 1'b0;
        case (state)
            IDLE: begin
                if (psel && !penable) begin
                    capture = 1'b1;
                    if (WAIT_STATES == 0) begin
                        state_nxt = RESP;
                        go_resp   = 1'b1;
                    end else begin
                        state_nxt = WAIT;
                        cnt_nxt   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (!psel) begin
                    state_nxt = IDLE;
                    cnt_nxt   = 4'd0;
                end else if (cnt == 4'd0) begin
                    state_nxt = RESP;
                    go_resp   = 1'b1;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            pready    <= 1'b0;
            pslverr   <= 1'b0;
            prdata    <= 32'd0;
            lat_write <= 1'b0;
            lat_err   <= 1'b0;
            lat_idx   <= '0;
            lat_wdata <= 32'd0;
            lat_strb  <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (capture) begin
                lat_write <= pwrite;
                lat_err   <= dec_err;
                lat_idx   <= dec_idx;
                lat_wdata <= pwdata;
                lat_strb  <= pstrb;
            end
            if (go_resp) begin
                pready  <= 1'b1;
                pslverr <= x_err;
                prdata  <= (!x_write && !x_err) ? mem[x_idx] : 32'd0;
            end else if (state == RESP) begin
                pready  <= 1'b0;
                pslverr <= 1'b0;
            end
        end
    end

    // Array is not reset; rst gating keeps an aborted transfer from committing.
    always_ff @(posedge clk) begin
        if (go_resp && x_write && !x_err && !rst) begin
            for (int b = 0; b < 4; b++) begin
                if (x_strb[b]) mem[x_idx][8*b +: 8] <= x_wdata[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_dmem_apb_slave.sv
// Scoreboard bench for dmem_apb_slave: three instances with 0, 3 and 4 wait
// states share a clock; a negedge monitor checks every pready response.
module tb_dmem_apb_slave;

    localparam int N = 3;

    logic        clk, rst;
    logic        psel    [N];
    logic        penable [N];
    logic        pwrite  [N];
    logic [31:0] paddr   [N];
    logic [31:0] pwdata  [N];
    logic [3:0]  pstrb   [N];
    logic [31:0] prdata  [N];
    logic        pready  [N];
    logic        pslverr [N];

    typedef struct {
        int          dut;
        logic        err;
        logic [31:0] data;
    } exp_t;

    exp_t sb [$];
    exp_t e;
    int   vec;
    int   miss;

    function automatic int ws(input int d);
        return (d == 0) ? 0 : ((d == 1) ? 3 : 4);
    endfunction

    for (genvar g = 0; g < N; g++) begin : g_dut
        localparam int WSG = (g == 0) ? 0 : ((g == 1) ? 3 : 4);
        dmem_apb_slave #(.DEPTH(16), .BASE_ADDR(32'h0), .WAIT_STATES(WSG)) u_dut (
            .clk     (clk),
            .rst     (rst),
            .psel    (psel[g]),
            .penable (penable[g]),
            .pwrite  (pwrite[g]),
            .paddr   (paddr[g]),
            .pwdata  (pwdata[g]),
            .pstrb   (pstrb[g]),
            .prdata  (prdata[g]),
            .pready  (pready[g]),
            .pslverr (pslverr[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: any pready pulse must match the oldest expected response
    always @(negedge clk) begin
        for (int d = 0; d < N; d++) begin
            if (pready[d]) begin
                vec++;
                if (sb.size() == 0) begin
                    miss++;
                    $display("FAIL spurious_pready dut%0d: got pready=1 err=%0b data=%h, want no response",
                             d, pslverr[d], prdata[d]);
                end else begin
                    e = sb.pop_front();
                    if (e.dut != d || pslverr[d] !== e.err || prdata[d] !== e.data) begin
                        miss++;
                        $display("FAIL resp dut%0d: got err=%0b data=%h, want dut%0d err=%0b data=%h",
                                 d, pslverr[d], prdata[d], e.dut, e.err, e.data);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        vec++;
        if (got !== want) begin
            miss++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    task automatic setup(input int d, input logic w, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] s);
        @(posedge clk); #1;
        psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = w;
        paddr[d] = a;   pwdata[d] = wd;    pstrb[d] = s;
    endtask

    // Full transfer; leaves the bus in the pready cycle so the next setup can follow
    task automatic xfer(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] s, input logic ee, input logic [31:0] ed);
        int cyc;
        sb.push_back('{d, ee, ed});
        setup(d, w, a, wd, s);
        @(posedge clk); #1;
        penable[d] = 1'b1;
        cyc = 1;
        while (!pready[d] && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk($sformatf("latency dut%0d", d), 32'(cyc), 32'(ws(d) + 1));
    endtask

    task automatic idle(input int d, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            psel[d] = 1'b0; penable[d] = 1'b0;
        end
    endtask

    initial begin
        vec = 0; miss = 0;
        rst = 1'b1;
        for (int d = 0; d < N; d++) begin
            psel[d] = 0; penable[d] = 0; pwrite[d] = 0;
            paddr[d] = 0; pwdata[d] = 0; pstrb[d] = 0;
        end
        #12;
        for (int d = 0; d < N; d++) begin
            chk($sformatf("reset pready dut%0d", d), 32'(pready[d]), 32'd0);
            chk($sformatf("reset pslverr dut%0d", d), 32'(pslverr[d]), 32'd0);
            chk($sformatf("reset prdata dut%0d", d), prdata[d], 32'd0);
        end
        @(negedge clk); rst = 1'b0;

        // Zero wait states: write/read, byte strobes, errors, null strobe, last word
        xfer(0, 1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 32'h0);
        xfer(0, 0, 32'h10, 32'h0,        4'hF, 0, 32'hDEADBEEF);
        xfer(0, 1, 32'h20, 32'h11223344, 4'hF, 0, 32'h0);
        xfer(0, 1, 32'h20, 32'hAABBCCDD, 4'b0101, 0, 32'h0);
        xfer(0, 0, 32'h20, 32'h0,        4'h0, 0, 32'h11BB33DD);
        xfer(0, 1, 32'h00, 32'h600DF00D, 4'hF, 0, 32'h0);
        xfer(0, 0, 32'h40, 32'h0,        4'hF, 1, 32'h0);
        xfer(0, 1, 32'h02, 32'hFFFFFFFF, 4'hF, 1, 32'h0);
        xfer(0, 0, 32'h00, 32'h0,        4'hF, 0, 32'h600DF00D);
        xfer(0, 1, 32'h10, 32'h12345678, 4'h0, 0, 32'h0);
        xfer(0, 0, 32'h10, 32'h0,        4'hF, 0, 32'hDEADBEEF);
        xfer(0, 1, 32'h3C, 32'h0BADCAFE, 4'hF, 0, 32'h0);
        xfer(0, 0, 32'h3C, 32'h0,        4'hF, 0, 32'h0BADCAFE);
        idle(0, 1);

        // Access phase without setup must be ignored
        @(posedge clk); #1;
        psel[0] = 1'b1; penable[0] = 1'b1;
        idle(0, 0);
        repeat (3) @(posedge clk);
        #1 chk("no_setup pready", 32'(pready[0]), 32'd0);
        idle(0, 2);

        // Three wait states, back-to-back write then read
        xfer(1, 1, 32'h04, 32'h12345678, 4'hF, 0, 32'h0);
        xfer(1, 0, 32'h04, 32'h0,        4'hF, 0, 32'h12345678);
        idle(1, 2);

        // Abort: psel drops in the 2nd access cycle of a write
        xfer(2, 1, 32'h08, 32'hCAFEF00D, 4'hF, 0, 32'h0);
        idle(2, 1);
        setup(2, 1, 32'h08, 32'hBAD0BAD0, 4'hF);
        @(posedge clk); #1 penable[2] = 1'b1;
        @(posedge clk); #1 begin psel[2] = 1'b0; penable[2] = 1'b0; end
        idle(2, 6);
        xfer(2, 0, 32'h08, 32'h0, 4'hF, 0, 32'hCAFEF00D);

        // Reset during WAIT of a write
        xfer(2, 0, 32'h08, 32'h0, 4'hF, 0, 32'hCAFEF00D);
        setup(2, 1, 32'h08, 32'h55555555, 4'hF);
        @(posedge clk); #1 penable[2] = 1'b1;
        @(posedge clk); #1 rst = 1'b1;
        #1;
        chk("midrst pready", 32'(pready[2]), 32'd0);
        chk("midrst pslverr", 32'(pslverr[2]), 32'd0);
        chk("midrst prdata", prdata[2], 32'd0);
        psel[2] = 1'b0; penable[2] = 1'b0;
        @(negedge clk); rst = 1'b0;
        xfer(2, 0, 32'h08, 32'h0, 4'hF, 0, 32'hCAFEF00D);
        idle(2, 3);

        chk("scoreboard drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
